ebox_mem_seq: RTL and testbench
===============================

EBOX_MEM_SEQ -- requirements
Module: ebox_mem_seq

Interface
REQ-001 The block SHALL have the port clk3_mcl_h, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port mr_reset_04_h, input, 1 bit: reset, asynchronous, active-high.
REQ-003 The block SHALL have the port mcl_mbox_cyc_req_h, input, 1 bit: memory cycle request from MCL.
REQ-004 The block SHALL have the ports mcl2_vma_read_l, mcl2_vma_write_l, mcl2_vma_user_l, input, 1 bit each: cycle function qualifiers, active-low.
REQ-005 The block SHALL have the ports mcl2_vma_pause_h, mcl6_vma_fetch_h and mcl5_adr_err_h, input, 1 bit each: read-pause-write, fetch and address-error qualifiers.
REQ-006 The block SHALL have the port vma_13to35_h, input, 23 bits: virtual address.
REQ-007 The block SHALL have the port ar_h, input, 36 bits: store data.
REQ-008 The block SHALL have the ports mbox_ack_h, mbox_rd_valid_h and mbox_page_fail_h, input, 1 bit each: MBOX accept, read data valid and page fail.
REQ-009 The block SHALL have the port mbox_data_h, input, 36 bits: read data.
REQ-010 The block SHALL have the port mbox_req_h, output, 1 bit: cycle request to MBOX.
REQ-011 The block SHALL have the port mbox_adr_h, output, 23 bits: latched address.
REQ-012 The block SHALL have the port mbox_func_h, output, 4 bits: {read, write, user, fetch}.
REQ-013 The block SHALL have the port mbox_wr_data_h, output, 36 bits: latched store data.
REQ-014 The block SHALL have the ports mem_data_h (output, 36 bits) and mcl_load_ar_h (output, 1 bit): read data and the one-cycle AR load strobe.
REQ-015 The block SHALL have the ports ebox_mem_wait_h, page_fail_trap_h, adr_err_trap_h and mem_timeout_h, output, 1 bit each: EBOX stall, plus one-cycle fault pulses.

Function
REQ-016 States SHALL be IDLE, REQ, RD_WAIT and PAUSE.
REQ-017 In IDLE with mcl_mbox_cyc_req_h=1 and read or write asserted, the block SHALL latch address, function and ar_h (ar_h only if write) and enter REQ the next cycle.
REQ-018 A request with neither read nor write asserted SHALL be ignored.
REQ-019 A request with mcl5_adr_err_h=1 SHALL NOT enter REQ; it SHALL pulse adr_err_trap_h for one cycle and remain in IDLE.
REQ-020 mbox_req_h SHALL equal (state==REQ), and mbox_adr_h, mbox_func_h and mbox_wr_data_h SHALL be held stable throughout REQ.
REQ-021 REQ with mbox_ack_h=1: a write SHALL go to IDLE, and a read SHALL go to RD_WAIT.
REQ-022 In RD_WAIT with mbox_rd_valid_h=1, the block SHALL capture mbox_data_h into mem_data_h and pulse mcl_load_ar_h one cycle, then go to PAUSE if pause was latched, else to IDLE.
REQ-023 In PAUSE, a request with write asserted SHALL latch ar_h and the write function, keep the latched address, and enter REQ; requests without write SHALL be ignored in PAUSE.
REQ-024 mbox_page_fail_h=1 in REQ or RD_WAIT SHALL take priority over a simultaneous ack or valid: no AR load, a one-cycle page_fail_trap_h pulse, and next state IDLE.
REQ-025 ebox_mem_wait_h SHALL be 1 in REQ and RD_WAIT, and 0 in IDLE and PAUSE.
REQ-026 Read-to-AR latency SHALL be exactly one cycle after mbox_rd_valid_h.

Reset
REQ-027 Asserting mr_reset_04_h SHALL immediately force IDLE and clear all outputs and latches to 0, including during REQ, RD_WAIT and PAUSE, with no trap pulse.
REQ-028 After reset deassertion, the first request SHALL be accepted normally.

Configuration
REQ-029 When MEM_TIMEOUT_EN is defined, an 8-bit counter SHALL clear on entry to REQ and RD_WAIT and increment each cycle in those states; at a count of 255 without ack or valid, the block SHALL pulse mem_timeout_h one cycle and go to IDLE.
REQ-030 When MEM_TIMEOUT_EN is undefined, there SHALL be no counter, mem_timeout_h SHALL be tied to 0, and the block SHALL wait indefinitely.

Verification
REQ-031 Read at vma=23'o1234567 with ack after 2 cycles and valid 3 cycles later carrying data 36'o123456654321 -> mem_data_h equals that data, one mcl_load_ar_h pulse, final state IDLE.
REQ-032 Read-pause at 23'o100, then a write request with ar_h=36'o777 -> mbox_adr_h is 23'o100 for both cycles and the write function is {0,1,x,x}.
REQ-033 Page fail on the same cycle as mbox_rd_valid_h -> page_fail_trap_h pulses and mcl_load_ar_h stays 0.
REQ-034 Request with mcl5_adr_err_h=1 -> adr_err_trap_h pulses and mbox_req_h never asserts.
REQ-035 Reset asserted in RD_WAIT -> outputs are 0 at once, and a later valid is ignored.
REQ-036 With MEM_TIMEOUT_EN defined and no ack -> mem_timeout_h pulses after 256 REQ cycles.

Source files
------------

// File: rtl/ebox_mem_seq.sv
// rtl/ebox_mem_seq.sv - EBOX memory cycle sequencer between MCL and MBOX
//
// Purpose: accepts memory cycle requests from MCL, latches address/function/
// store data, handshakes the cycle with MBOX, returns read data to AR and
// raises one-cycle fault pulses for page fail, address error and timeout.
//
// Optional feature: define MEM_TIMEOUT_EN to add an 8-bit wait-timeout counter
// in REQ/RD_WAIT; otherwise the sequencer waits indefinitely and
// mem_timeout_h is tied to 0.
//
// Ports:
//   clk3_mcl_h          clock, rising edge
//   mr_reset_04_h       asynchronous active-high reset
//   mcl_mbox_cyc_req_h  cycle request from MCL
//   mcl2_vma_*_l        read/write/user qualifiers (active-low)
//   mcl2_vma_pause_h    read-pause-write qualifier
//   mcl6_vma_fetch_h    instruction fetch qualifier
//   mcl5_adr_err_h      address error on the request
//   vma_13to35_h        virtual address
//   ar_h                store data
//   mbox_ack_h / mbox_rd_valid_h / mbox_page_fail_h / mbox_data_h  MBOX side
//   mbox_req_h / mbox_adr_h / mbox_func_h / mbox_wr_data_h         MBOX request
//   mem_data_h / mcl_load_ar_h                                      read return
//   ebox_mem_wait_h     EBOX stall
//   page_fail_trap_h / adr_err_trap_h / mem_timeout_h              fault pulses
module ebox_mem_seq (
  input  logic        clk3_mcl_h,
  input  logic        mr_reset_04_h,
  input  logic        mcl_mbox_cyc_req_h,
  input  logic        mcl2_vma_read_l,
  input  logic        mcl2_vma_write_l,
  input  logic        mcl2_vma_user_l,
  input  logic        mcl2_vma_pause_h,
  input  logic        mcl6_vma_fetch_h,
  input  logic        mcl5_adr_err_h,
  input  logic [22:0] vma_13to35_h,
  input  logic [35:0] ar_h,
  input  logic        mbox_ack_h,
  input  logic        mbox_rd_valid_h,
  input  logic        mbox_page_fail_h,
  input  logic [35:0] mbox_data_h,
  output logic        mbox_req_h,
  output logic [22:0] mbox_adr_h,
  output logic [3:0]  mbox_func_h,
  output logic [35:0] mbox_wr_data_h,
  output logic [35:0] mem_data_h,
  output logic        mcl_load_ar_h,
  output logic        ebox_mem_wait_h,
  output logic        page_fail_trap_h,
  output logic        adr_err_trap_h,
  output logic        mem_timeout_h
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_PAUSE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [22:0] adr_q, adr_d;
  logic [3:0]  func_q, func_d;
  logic [35:0] wr_data_q, wr_data_d;
  logic [35:0] mem_data_q, mem_data_d;
  logic        load_ar_q, load_ar_d;
  logic        pf_trap_q, pf_trap_d;
  logic        ae_trap_q, ae_trap_d;
  logic        pause_q, pause_d;

`ifdef MEM_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
`endif

  logic rd_req, wr_req, usr_req;
  assign rd_req  = ~mcl2_vma_read_l;
  assign wr_req  = ~mcl2_vma_write_l;
  assign usr_req = ~mcl2_vma_user_l;

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    func_d     = func_q;
    wr_data_d  = wr_data_q;
    mem_data_d = mem_data_q;
    pause_d    = pause_q;
    load_ar_d  = 1'b0;
    pf_trap_d  = 1'b0;
    ae_trap_d  = 1'b0;
`ifdef MEM_TIMEOUT_EN
    timeout_d  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (mcl_mbox_cyc_req_h && (rd_req || wr_req)) begin
          if (mcl5_adr_err_h) begin
            ae_trap_d = 1'b1;
          end else begin
            adr_d   = vma_13to35_h;
            func_d  = {rd_req, wr_req, usr_req, mcl6_vma_fetch_h};
            pause_d = mcl2_vma_pause_h;
            if (wr_req) wr_data_d = ar_h;
            state_d = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        // Page fail wins over a same-cycle ack.
        if (mbox_page_fail_h) begin
          pf_trap_d = 1'b1;
          pause_d   = 1'b0;
          state_d   = ST_IDLE;
        end else if (mbox_ack_h) begin
          if (func_q[3]) begin
            state_d = ST_RD_WAIT;
          end else begin
            pause_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == 8'hff) begin
          timeout_d = 1'b1;
          pause_d   = 1'b0;
          state_d   = ST_IDLE;
        end
`endif
      end

      ST_RD_WAIT: begin
        if (mbox_page_fail_h) begin
          pf_trap_d = 1'b1;
          pause_d   = 1'b0;
          state_d   = ST_IDLE;
        end else if (mbox_rd_valid_h) begin
          mem_data_d = mbox_data_h;
          load_ar_d  = 1'b1;
          // The pause flag is consumed here; PAUSE itself remembers it.
          state_d    = pause_q ? ST_PAUSE : ST_IDLE;
          pause_d    = 1'b0;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == 8'hff) begin
          timeout_d = 1'b1;
          pause_d   = 1'b0;
          state_d   = ST_IDLE;
        end
`endif
      end

      ST_PAUSE: begin
        // Only the write half of read-pause-write may follow; address is kept.
        if (mcl_mbox_cyc_req_h && wr_req) begin
          wr_data_d = ar_h;
          func_d    = {1'b0, 1'b1, usr_req, mcl6_vma_fetch_h};
          state_d   = ST_REQ;
        end
      end

      default: state_d = ST_IDLE;
    endcase

`ifdef MEM_TIMEOUT_EN
    // Counts cycles spent in the current REQ/RD_WAIT visit; restarts on entry.
    if ((state_d == state_q) && ((state_q == ST_REQ) || (state_q == ST_RD_WAIT)))
      cnt_d = cnt_q + 8'd1;
    else
      cnt_d = 8'd0;
`endif
  end

  always_ff @(posedge clk3_mcl_h or posedge mr_reset_04_h) begin
    if (mr_reset_04_h) begin
      state_q    <= ST_IDLE;
      adr_q      <= '0;
      func_q     <= '0;
      wr_data_q  <= '0;
      mem_data_q <= '0;
      load_ar_q  <= 1'b0;
      pf_trap_q  <= 1'b0;
      ae_trap_q  <= 1'b0;
      pause_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      func_q     <= func_d;
      wr_data_q  <= wr_data_d;
      mem_data_q <= mem_data_d;
      load_ar_q  <= load_ar_d;
      pf_trap_q  <= pf_trap_d;
      ae_trap_q  <= ae_trap_d;
      pause_q    <= pause_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign mbox_req_h       = (state_q == ST_REQ);
  assign ebox_mem_wait_h  = (state_q == ST_REQ) || (state_q == ST_RD_WAIT);
  assign mbox_adr_h       = adr_q;
  assign mbox_func_h      = func_q;
  assign mbox_wr_data_h   = wr_data_q;
  assign mem_data_h       = mem_data_q;
  assign mcl_load_ar_h    = load_ar_q;
  assign page_fail_trap_h = pf_trap_q;
  assign adr_err_trap_h   = ae_trap_q;
`ifdef MEM_TIMEOUT_EN
  assign mem_timeout_h    = timeout_q;
`else
  assign mem_timeout_h    = 1'b0;
`endif

endmodule

// File: tb/tb_ebox_mem_seq.sv
// tb/tb_ebox_mem_seq.sv - directed self-checking bench for ebox_mem_seq
module tb_ebox_mem_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc_req, read_l, write_l, user_l, pause, fetch, adr_err;
  logic [22:0] vma;
  logic [35:0] ar;
  logic        ack, rd_valid, page_fail;
  logic [35:0] mbox_data;
  logic        mbox_req;
  logic [22:0] mbox_adr;
  logic [3:0]  mbox_func;
  logic [35:0] mbox_wr_data, mem_data;
  logic        load_ar, mem_wait, pf_trap, ae_trap, timeout;

  int tests  = 0;
  int failed = 0;

  localparam logic [35:0] D1 = 36'o123456654321;
  localparam logic [35:0] D2 = 36'o111222333444;
  localparam logic [35:0] D3 = 36'o765432101234;

  always #5 clk = ~clk;

  ebox_mem_seq dut (
    .clk3_mcl_h         (clk),
    .mr_reset_04_h      (rst),
    .mcl_mbox_cyc_req_h (cyc_req),
    .mcl2_vma_read_l    (read_l),
    .mcl2_vma_write_l   (write_l),
    .mcl2_vma_user_l    (user_l),
    .mcl2_vma_pause_h   (pause),
    .mcl6_vma_fetch_h   (fetch),
    .mcl5_adr_err_h     (adr_err),
    .vma_13to35_h       (vma),
    .ar_h               (ar),
    .mbox_ack_h         (ack),
    .mbox_rd_valid_h    (rd_valid),
    .mbox_page_fail_h   (page_fail),
    .mbox_data_h        (mbox_data),
    .mbox_req_h         (mbox_req),
    .mbox_adr_h         (mbox_adr),
    .mbox_func_h        (mbox_func),
    .mbox_wr_data_h     (mbox_wr_data),
    .mem_data_h         (mem_data),
    .mcl_load_ar_h      (load_ar),
    .ebox_mem_wait_h    (mem_wait),
    .page_fail_trap_h   (pf_trap),
    .adr_err_trap_h     (ae_trap),
    .mem_timeout_h      (timeout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {req, wait, load_ar, pf_trap, ae_trap, timeout}
  function automatic logic [5:0] ctl();
    return {mbox_req, mem_wait, load_ar, pf_trap, ae_trap, timeout};
  endfunction

  task automatic idle_inputs();
    cyc_req = 0; read_l = 1; write_l = 1; user_l = 1; pause = 0; fetch = 0;
    adr_err = 0; ack = 0; rd_valid = 0; page_fail = 0;
  endtask

  initial begin
    idle_inputs();
    vma = '0; ar = '0; mbox_data = '0;
    rst = 1;
    tick(); tick();
    check("reset_ctl", ctl(), 6'b000000);
    check("reset_data", {mbox_adr, mbox_func, mbox_wr_data, mem_data} == '0, 1'b1);
    rst = 0;
    tick();

    // Read at 1234567: ack after 2 REQ cycles, valid 3 cycles later.
    cyc_req = 1; read_l = 0; vma = 23'o1234567;
    tick();
    idle_inputs(); vma = 23'o7;
    check("rd_req1", ctl(), 6'b110000);
    check("rd_adr", mbox_adr, 23'o1234567);
    check("rd_func", mbox_func, 4'b1000);
    tick();
    check("rd_req2", {ctl(), mbox_adr}, {6'b110000, 23'o1234567});
    ack = 1;
    tick();
    ack = 0;
    check("rd_wait1", ctl(), 6'b010000);
    tick(); tick();
    check("rd_wait3", ctl(), 6'b010000);
    rd_valid = 1; mbox_data = D1;
    tick();
    rd_valid = 0; mbox_data = '0;
    check("rd_load", ctl(), 6'b001000);
    check("rd_data", mem_data, D1);
    tick();
    check("rd_done", ctl(), 6'b000000);
    check("rd_data_held", mem_data, D1);

    // Read-pause-write at 100.
    cyc_req = 1; read_l = 0; pause = 1; vma = 23'o100;
    tick();
    idle_inputs(); vma = 23'o5;
    check("rp_req", {ctl(), mbox_adr}, {6'b110000, 23'o100});
    ack = 1;
    tick();
    ack = 0;
    rd_valid = 1; mbox_data = D2;
    tick();
    rd_valid = 0;
    check("rp_pause", ctl(), 6'b001000);
    check("rp_data", mem_data, D2);
    cyc_req = 1; read_l = 0;
    tick();
    check("rp_read_ignored", ctl(), 6'b000000);
    read_l = 1; write_l = 0; ar = 36'o777; vma = 23'o4444;
    tick();
    idle_inputs();
    check("rp_wr_req", ctl(), 6'b110000);
    check("rp_wr_adr", mbox_adr, 23'o100);
    check("rp_wr_func", mbox_func[3:2], 2'b01);
    check("rp_wr_data", mbox_wr_data, 36'o777);
    tick();
    check("rp_wr_adr2", mbox_adr, 23'o100);
    ack = 1;
    tick();
    ack = 0;
    check("rp_wr_done", ctl(), 6'b000000);

    // Plain user write, and a request with neither read nor write.
    cyc_req = 1; write_l = 0; user_l = 0; ar = 36'o555; vma = 23'o222;
    tick();
    idle_inputs();
    check("wr_func", {mbox_req, mbox_func, mbox_wr_data}, {1'b1, 4'b0110, 36'o555});
    ack = 1;
    tick();
    ack = 0;
    check("wr_idle", ctl(), 6'b000000);
    cyc_req = 1;
    tick();
    cyc_req = 0;
    check("noop_ignored", ctl(), 6'b000000);

    // Page fail on the same cycle as read valid.
    cyc_req = 1; read_l = 0; vma = 23'o333;
    tick();
    idle_inputs();
    ack = 1;
    tick();
    ack = 0;
    rd_valid = 1; page_fail = 1; mbox_data = D3;
    tick();
    rd_valid = 0; page_fail = 0;
    check("pf_rd_trap", ctl(), 6'b000100);
    check("pf_rd_data", mem_data, D2);
    tick();
    check("pf_rd_clear", ctl(), 6'b000000);

    // Page fail on the same cycle as ack in REQ.
    cyc_req = 1; read_l = 0;
    tick();
    idle_inputs();
    ack = 1; page_fail = 1;
    tick();
    ack = 0; page_fail = 0;
    check("pf_req_trap", ctl(), 6'b000100);

    // Address error request.
    cyc_req = 1; read_l = 0; adr_err = 1;
    tick();
    idle_inputs();
    check("ae_trap", ctl(), 6'b000010);
    tick();
    check("ae_clear", ctl(), 6'b000000);

    // Reset during RD_WAIT; a later valid is ignored.
    cyc_req = 1; read_l = 0; vma = 23'o4567;
    tick();
    idle_inputs();
    ack = 1;
    tick();
    ack = 0;
    check("rst_in_rdwait", ctl(), 6'b010000);
    rst = 1;
    #1;
    check("rst_async_ctl", ctl(), 6'b000000);
    check("rst_async_data", {mbox_adr, mbox_func, mbox_wr_data, mem_data} == '0, 1'b1);
    rd_valid = 1; mbox_data = D1;
    tick();
    rst = 0;
    tick();
    rd_valid = 0;
    check("rst_valid_ignored", {ctl(), mem_data}, {6'b000000, 36'd0});

    // First request after reset is accepted.
    cyc_req = 1; write_l = 0; ar = 36'o4321; vma = 23'o17;
    tick();
    idle_inputs();
    check("post_rst_req", {ctl(), mbox_adr, mbox_wr_data}, {6'b110000, 23'o17, 36'o4321});

`ifdef MEM_TIMEOUT_EN
    for (int i = 2; i <= 256; i++) tick();
    check("to_still_req", ctl(), 6'b110000);
    tick();
    check("to_pulse", ctl(), 6'b000001);
    tick();
    check("to_clear", ctl(), 6'b000000);
`else
    for (int i = 0; i < 300; i++) begin
      tick();
      check("no_timeout", ctl(), 6'b110000);
    end
    ack = 1;
    tick();
    ack = 0;
    check("late_ack", ctl(), 6'b000000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
